rip_axi_sram_slave: RTL and testbench

//  AXI4 slave terminating one rip_axi_interface (slave modport); backs the CPU's AXI master with on-chip SRAM.

---
 rtl/rip_axi_pkg.sv | 28 ++
 rtl/rip_axi_interface.sv | 78 +++++++
 rtl/rip_axi_sram_bank.sv | 42 ++++
 rtl/rip_axi_sram_slave.sv | 219 +++++++++++++++++++++
 tb/tb_rip_axi_sram_slave.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/rip_axi_pkg.sv
// Shared AXI4 encodings and the burst address-step helper used by both the read and write paths.
package rip_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t OKAY   = 2'b00;
    localparam axi_resp_t SLVERR = 2'b10;
    localparam axi_resp_t DECERR = 2'b11;

    // Widest supported address; callers cast down to their own width, which gives the full-width wrap.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst);
        logic [63:0] nxt;
        nxt = addr;
        if (burst == INCR) begin
            nxt = addr + (64'd1 << size);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rip_axi_interface.sv
// AXI4 bundle (all five channels) with master and slave views.
interface rip_axi_interface #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/rip_axi_sram_bank.sv
// Purpose: simple dual-port SRAM, one byte-enabled write port and one read port.
// Latency: read data registered, valid 1 cycle after re; same-word read+write returns old data.
// Backpressure: none; rdata holds its value whenever re is low.
module rip_axi_sram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Array itself is never reset; only the output register is, so the bus sees zero data out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rip_axi_sram_slave.sv
// Purpose: AXI4 slave backing an on-chip SRAM; independent read/write FSMs, FIXED/INCR bursts, strobes.
// Latency: first R beat 1 cycle after AR handshake, then 1 beat/cycle; B 1 cycle after the last W beat.
// Backpressure: one burst in flight per direction; AW/AR blocked until the previous B/RLAST handshake.
module rip_axi_sram_slave
    import rip_axi_pkg::*;
#(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic             clk,
    input logic             rstn,
    rip_axi_interface.slave axi
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(MEM_WORDS * NB);

    function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) < WIN_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LOG2B);
    endfunction

    function automatic logic unsup(input logic [2:0] size, input logic [1:0] burst);
        return !(burst == FIXED || burst == INCR) || (size > 3'(LOG2B));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [2:0] size, input logic [1:0] burst);
        return ADDR_WIDTH'(axi_next_addr(64'(a), size, burst));
    endfunction

    // ---------------- write side ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t              w_state, w_state_nxt;
    logic                  awready_q;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q, w_cnt_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic                  w_unsup_q, w_dec_q, w_slv_q;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, w_rdy, b_vld, mem_we;

    assign aw_hs       = axi.awvalid & awready_q;
    assign w_hs        = axi.wvalid & w_rdy;
    assign b_hs        = axi.bready & b_vld;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign mem_we      = w_hs & ~w_unsup_q & in_win(w_addr_q);

    always_comb begin
        w_state_nxt = w_state;
        w_rdy       = 1'b0;
        b_vld       = 1'b0;
        case (w_state)
            W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
            W_DATA: begin
                w_rdy = 1'b1;
                if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (b_hs) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_unsup_q <= 1'b0;
            w_dec_q   <= 1'b0;
            w_slv_q   <= 1'b0;
        end else begin
            w_state   <= w_state_nxt;
            awready_q <= (w_state_nxt == W_IDLE);
            if (aw_hs) begin
                w_id_q    <= axi.awid;
                w_addr_q  <= axi.awaddr;
                w_len_q   <= axi.awlen;
                w_size_q  <= axi.awsize;
                w_burst_q <= axi.awburst;
                w_unsup_q <= unsup(axi.awsize, axi.awburst);
                w_cnt_q   <= '0;
                w_dec_q   <= 1'b0;
                w_slv_q   <= 1'b0;
            end
            if (w_hs) begin
                w_cnt_q  <= w_cnt_q + 8'd1;
                w_addr_q <= step(w_addr_q, w_size_q, w_burst_q);
                if (w_unsup_q || (axi.wlast != w_last_beat)) w_slv_q <= 1'b1;
                if (!w_unsup_q && !in_win(w_addr_q))         w_dec_q <= 1'b1;
            end
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = w_rdy;
    assign axi.bvalid  = b_vld;
    assign axi.bid     = w_id_q;
    assign axi.bresp   = w_dec_q ? DECERR : (w_slv_q ? SLVERR : OKAY);

    // ---------------- read side ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t              r_state, r_state_nxt;
    logic                  arready_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q, rd_addr;
    logic [7:0]            r_len_q, r_cnt_q;
    logic [2:0]            r_size_q, rd_size;
    logic [1:0]            r_burst_q, rd_burst;
    logic                  r_unsup_q, rd_unsup, r_last_q;
    axi_resp_t             r_resp_q, beat_resp;
    logic                  ar_hs, r_hs, r_last_beat, r_vld, rd_en;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign ar_hs       = axi.arvalid & arready_q;
    assign r_hs        = axi.rready & r_vld;
    assign r_last_beat = (r_cnt_q == r_len_q);
    assign rd_en       = ar_hs | (r_hs & ~r_last_beat);

    // Beat 0 is issued straight from the AR channel; later beats from the captured state.
    assign rd_addr   = ar_hs ? axi.araddr  : r_addr_q;
    assign rd_size   = ar_hs ? axi.arsize  : r_size_q;
    assign rd_burst  = ar_hs ? axi.arburst : r_burst_q;
    assign rd_unsup  = ar_hs ? unsup(axi.arsize, axi.arburst) : r_unsup_q;
    assign beat_resp = rd_unsup ? SLVERR : (in_win(rd_addr) ? OKAY : DECERR);

    always_comb begin
        r_state_nxt = r_state;
        r_vld       = 1'b0;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
            R_DATA: begin
                r_vld = 1'b1;
                if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_unsup_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_resp_q  <= OKAY;
        end else begin
            r_state   <= r_state_nxt;
            arready_q <= (r_state_nxt == R_IDLE);
            if (ar_hs) begin
                r_id_q    <= axi.arid;
                r_len_q   <= axi.arlen;
                r_size_q  <= axi.arsize;
                r_burst_q <= axi.arburst;
                r_unsup_q <= unsup(axi.arsize, axi.arburst);
                r_cnt_q   <= '0;
            end else if (rd_en) begin
                r_cnt_q   <= r_cnt_q + 8'd1;
            end
            if (rd_en) begin
                r_addr_q <= step(rd_addr, rd_size, rd_burst);
                r_resp_q <= beat_resp;
                r_last_q <= ar_hs ? (axi.arlen == 8'd0) : ((r_cnt_q + 8'd1) == r_len_q);
            end
        end
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = r_vld;
    assign axi.rid     = r_id_q;
    assign axi.rresp   = r_resp_q;
    assign axi.rlast   = r_vld & r_last_q;
    assign axi.rdata   = (r_resp_q == OKAY) ? bank_rdata : '0;

    rip_axi_sram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_bank (
        .clk   (clk),
        .rstn  (rstn),
        .we    (mem_we),
        .waddr (word_idx(w_addr_q)),
        .wstrb (axi.wstrb),
        .wdata (axi.wdata),
        .re    (rd_en),
        .raddr (word_idx(rd_addr)),
        .rdata (bank_rdata)
    );

    logic ign_unused;
    assign ign_unused = ^{axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion, axi.wid,
                          axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion};

endmodule

// File: tb/tb_rip_axi_sram_slave.sv
// Directed bench for rip_axi_sram_slave: writes, reads, strobes, error responses, concurrency, reset mid-burst.
module tb_rip_axi_sram_slave;
    import rip_axi_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   nasrt = 0;
    int   nfail = 0;

    logic [31:0] wr_dat [8];
    logic [3:0]  wr_stb [8];
    logic [31:0] exp_dat [8];
    logic [1:0]  exp_rsp [8];

    always #5 clk = ~clk;

    rip_axi_interface #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_if ();

    rip_axi_sram_slave #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(4096), .BASE_ADDR(32'h0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .axi  (axi_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        axi_if.awid = id; axi_if.awaddr = addr; axi_if.awlen = len;
        axi_if.awsize = size; axi_if.awburst = burst; axi_if.awvalid = 1'b1;
        for (int k = 0; k < 40 && axi_if.awready !== 1'b1; k++) tick();
        chk("aw_accept", axi_if.awready, 1);
        tick();
        axi_if.awvalid = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int last_idx, input logic [1:0] exp_resp,
                            input int bhold);
        aw_send(id, addr, len, 3'd2, burst);
        for (int i = 0; i <= int'(len); i++) begin
            axi_if.wdata = wr_dat[i]; axi_if.wstrb = wr_stb[i];
            axi_if.wlast = (i == last_idx); axi_if.wvalid = 1'b1;
            for (int k = 0; k < 40 && axi_if.wready !== 1'b1; k++) tick();
            chk("w_accept", axi_if.wready, 1);
            tick();
        end
        axi_if.wvalid = 1'b0; axi_if.wlast = 1'b0;
        for (int k = 0; k < 40 && axi_if.bvalid !== 1'b1; k++) tick();
        chk("b_valid", axi_if.bvalid, 1);
        for (int h = 0; h < bhold; h++) begin
            chk("b_hold_valid", axi_if.bvalid, 1);
            chk("b_hold_id", axi_if.bid, id);
            chk("b_hold_awready", axi_if.awready, 0);
            tick();
        end
        chk("b_id", axi_if.bid, id);
        chk("b_resp", axi_if.bresp, exp_resp);
        axi_if.bready = 1'b1;
        tick();
        axi_if.bready = 1'b0;
        chk("b_drop", axi_if.bvalid, 0);
        chk("aw_ready_after_b", axi_if.awready, 1);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic toggle);
        axi_if.arid = id; axi_if.araddr = addr; axi_if.arlen = len;
        axi_if.arsize = 3'd2; axi_if.arburst = burst; axi_if.arvalid = 1'b1;
        for (int k = 0; k < 40 && axi_if.arready !== 1'b1; k++) tick();
        chk("ar_accept", axi_if.arready, 1);
        tick();
        axi_if.arvalid = 1'b0;
        chk("r_latency", axi_if.rvalid, 1);
        for (int i = 0; i <= int'(len); i++) begin
            if (toggle) begin
                axi_if.rready = 1'b0;
                tick();
                chk("r_hold_valid", axi_if.rvalid, 1);
                chk("r_hold_data", axi_if.rdata, exp_dat[i]);
            end
            axi_if.rready = 1'b1;
            chk("r_valid", axi_if.rvalid, 1);
            chk("r_data", axi_if.rdata, exp_dat[i]);
            chk("r_resp", axi_if.rresp, exp_rsp[i]);
            chk("r_last", axi_if.rlast, (i == int'(len)));
            chk("r_id", axi_if.rid, id);
            tick();
        end
        axi_if.rready = 1'b0;
        chk("r_done", axi_if.rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_if.awvalid = 0; axi_if.awid = 0; axi_if.awaddr = 0; axi_if.awlen = 0; axi_if.awsize = 0;
        axi_if.awburst = 0; axi_if.awlock = 0; axi_if.awcache = 0; axi_if.awprot = 0; axi_if.awqos = 0;
        axi_if.awregion = 0; axi_if.wid = 0; axi_if.wdata = 0; axi_if.wstrb = 0; axi_if.wlast = 0;
        axi_if.wvalid = 0; axi_if.bready = 0; axi_if.arvalid = 0; axi_if.arid = 0; axi_if.araddr = 0;
        axi_if.arlen = 0; axi_if.arsize = 0; axi_if.arburst = 0; axi_if.arlock = 0; axi_if.arcache = 0;
        axi_if.arprot = 0; axi_if.arqos = 0; axi_if.arregion = 0; axi_if.rready = 0;

        // 1: reset state, then a single-beat write and read
        repeat (3) tick();
        chk("rst_awready", axi_if.awready, 0);
        chk("rst_arready", axi_if.arready, 0);
        chk("rst_wready", axi_if.wready, 0);
        chk("rst_bvalid", axi_if.bvalid, 0);
        chk("rst_rvalid", axi_if.rvalid, 0);
        chk("rst_rlast", axi_if.rlast, 0);
        chk("rst_bid", axi_if.bid, 0);
        chk("rst_rid", axi_if.rid, 0);
        chk("rst_bresp", axi_if.bresp, 0);
        chk("rst_rresp", axi_if.rresp, 0);
        chk("rst_rdata", axi_if.rdata, 0);
        rstn = 1'b1;
        chk("rel_awready_same_cycle", axi_if.awready, 0);
        tick();
        chk("rel_awready", axi_if.awready, 1);
        chk("rel_arready", axi_if.arready, 1);

        wr_dat[0] = 32'hDEADBEEF; wr_stb[0] = 4'hF;
        wr_burst(4'd3, 32'h10, 8'd0, INCR, 0, OKAY, 0);
        exp_dat[0] = 32'hDEADBEEF; exp_rsp[0] = OKAY;
        rd_burst(4'd3, 32'h10, 8'd0, INCR, 1'b0);

        // 2: 4-beat INCR burst, streaming and stalled readback
        for (int i = 0; i < 4; i++) begin
            wr_dat[i] = 32'(i + 1); wr_stb[i] = 4'hF; exp_dat[i] = 32'(i + 1); exp_rsp[i] = OKAY;
        end
        wr_burst(4'd1, 32'h100, 8'd3, INCR, 3, OKAY, 0);
        rd_burst(4'd2, 32'h100, 8'd3, INCR, 1'b0);
        rd_burst(4'd5, 32'h100, 8'd3, INCR, 1'b1);

        // 3: byte strobes over existing data
        wr_dat[0] = 32'h11223344; wr_stb[0] = 4'hF;
        wr_dat[1] = 32'h11223344; wr_stb[1] = 4'hF;
        wr_burst(4'd4, 32'h200, 8'd1, INCR, 1, OKAY, 0);
        wr_dat[0] = 32'hAABBCCDD; wr_stb[0] = 4'b0100;
        wr_dat[1] = 32'hAABBCCDD; wr_stb[1] = 4'b0101;
        wr_burst(4'd4, 32'h200, 8'd1, INCR, 1, OKAY, 0);
        exp_dat[0] = 32'h11BB3344; exp_dat[1] = 32'h11BB33DD; exp_rsp[0] = OKAY; exp_rsp[1] = OKAY;
        rd_burst(4'd4, 32'h200, 8'd1, INCR, 1'b0);

        // 4: error paths
        exp_dat[0] = 0; exp_dat[1] = 0; exp_rsp[0] = DECERR; exp_rsp[1] = DECERR;
        rd_burst(4'd7, 32'h8000, 8'd1, INCR, 1'b0);
        exp_rsp[0] = SLVERR; exp_rsp[1] = SLVERR;
        rd_burst(4'd7, 32'h10, 8'd1, WRAP, 1'b0);
        wr_dat[0] = 32'h55555555; wr_stb[0] = 4'hF;
        wr_dat[1] = 32'h66666666; wr_stb[1] = 4'hF;
        wr_burst(4'd6, 32'h10, 8'd1, WRAP, 1, SLVERR, 0);
        exp_dat[0] = 32'hDEADBEEF; exp_rsp[0] = OKAY;
        rd_burst(4'd6, 32'h10, 8'd0, INCR, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr_dat[i] = 32'h300 + 32'(i); wr_stb[i] = 4'hF;
        end
        wr_burst(4'd8, 32'h300, 8'd2, INCR, 1, SLVERR, 0);

        // 5: concurrent write and read, B held off for 5 cycles
        for (int i = 0; i < 8; i++) begin
            wr_dat[i] = 32'hC0 + 32'(i); wr_stb[i] = 4'hF;
        end
        wr_burst(4'd2, 32'h800, 8'd7, INCR, 7, OKAY, 0);
        for (int i = 0; i < 8; i++) begin
            wr_dat[i] = 32'hA0 + 32'(i); exp_dat[i] = 32'hC0 + 32'(i); exp_rsp[i] = OKAY;
        end
        fork
            wr_burst(4'd9, 32'h400, 8'd7, INCR, 7, OKAY, 5);
            rd_burst(4'd10, 32'h800, 8'd7, INCR, 1'b0);
        join
        for (int i = 0; i < 8; i++) exp_dat[i] = 32'hA0 + 32'(i);
        rd_burst(4'd11, 32'h400, 8'd7, INCR, 1'b0);

        // 6: reset during beat 3 of an 8-beat read
        axi_if.arid = 4'd12; axi_if.araddr = 32'h800; axi_if.arlen = 8'd7;
        axi_if.arsize = 3'd2; axi_if.arburst = INCR; axi_if.arvalid = 1'b1;
        for (int k = 0; k < 40 && axi_if.arready !== 1'b1; k++) tick();
        chk("t6_ar_accept", axi_if.arready, 1);
        tick();
        axi_if.arvalid = 1'b0;
        axi_if.rready = 1'b1;
        tick();
        tick();
        chk("t6_beat3_data", axi_if.rdata, 32'hC2);
        rstn = 1'b0;
        #1;
        chk("t6_rvalid_in_reset", axi_if.rvalid, 0);
        axi_if.rready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_arready_after_release", axi_if.arready, 1);
        chk("t6_rvalid_after_release", axi_if.rvalid, 0);
        for (int i = 0; i < 8; i++) begin
            exp_dat[i] = 32'hC0 + 32'(i); exp_rsp[i] = OKAY;
        end
        rd_burst(4'd13, 32'h800, 8'd7, INCR, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
